writeback_unit: RTL and testbench

- Producer side of the CPU register-file write port.
- Accepts results from two execution sources, ALU and memory/load, over valid/ready handshakes, queues them in a small FIFO and drives the register-file write port (write address, write data, write flag) one entry per cycle.
- Keeps a per-register pending-write scoreboard so the issue logic can detect RAW hazards before reading operands.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/writeback_unit.sv | 176 +++++++++++++++++
 tb/tb_writeback_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback path: default widths,
// source-select encoding and the queued entry layout.
package wb_pkg;

    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_DATA_W     = 32;
    localparam int WB_ADDR_W     = 5;
    localparam int WB_CNT_W      = 2;

    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_ALU = 1'b1
    } src_sel_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with registered pointers and an occupancy counter one bit
// wider than the pointers; DEPTH must be a power of two so pointers wrap freely.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port producer: arbitrates ALU/load results into a FIFO,
// drives one registered write per cycle and tracks pending writes per register.
// Optional macro WB_FORWARD_EN adds same-cycle forwarding outputs.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int CNT_W      = WB_CNT_W
) (
    input  logic              clk_w_i,
    input  logic              res_w_i_h,
    input  logic              alu_valid_w_i,
    input  logic [ADDR_W-1:0] alu_rd_w_i,
    input  logic [DATA_W-1:0] alu_data_w_i,
    output logic              alu_ready_w_o,
    input  logic              mem_valid_w_i,
    input  logic [ADDR_W-1:0] mem_rd_w_i,
    input  logic [DATA_W-1:0] mem_data_w_i,
    output logic              mem_ready_w_o,
    input  logic              iss_valid_w_i,
    input  logic [ADDR_W-1:0] iss_rd_w_i,
    output logic              iss_ready_w_o,
    input  logic              stall_w_i,
    input  logic [ADDR_W-1:0] chk_reg_1_w_i,
    input  logic [ADDR_W-1:0] chk_reg_2_w_i,
    output logic              chk_busy_1_w_o,
    output logic              chk_busy_2_w_o,
    output logic [ADDR_W-1:0] wr_reg_w_o,
    output logic [DATA_W-1:0] wr_data_w_o,
    output logic              reg_wr_flag_w_o
`ifdef WB_FORWARD_EN
    ,
    output logic              fwd_hit_1_w_o,
    output logic              fwd_hit_2_w_o,
    output logic [DATA_W-1:0] fwd_data_1_w_o,
    output logic [DATA_W-1:0] fwd_data_2_w_o
`endif
);

    // Handshake: a source transfers on the rising edge where valid && ready.
    // Ready depends only on pre-edge state plus the competing source's valid.

    localparam int              NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    entry_t           push_entry;
    entry_t           head;
    src_sel_t         src;
    logic             mem_rd_zero;
    logic             alu_rd_zero;
    logic             mem_ready;
    logic             alu_ready;
    logic             iss_ready;
    logic             iss_fire;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [CNT_W-1:0] cnt [NUM_REGS];

    assign mem_rd_zero = (mem_rd_w_i == '0);
    assign alu_rd_zero = (alu_rd_w_i == '0);
    assign pop         = !empty && !stall_w_i;

    // Writes to x0 are swallowed, so they are always ready even when full.
    always_comb begin
        mem_ready  = !full || mem_rd_zero;
        alu_ready  = (!full && !mem_valid_w_i) || alu_rd_zero;
        src        = mem_valid_w_i ? SRC_MEM : SRC_ALU;
        push       = 1'b0;
        push_entry = '{rd: alu_rd_w_i, data: alu_data_w_i};
        case (src)
            SRC_MEM: begin
                push       = !full && !mem_rd_zero;
                push_entry = '{rd: mem_rd_w_i, data: mem_data_w_i};
            end
            SRC_ALU: begin
                push       = alu_valid_w_i && !full && !alu_rd_zero;
                push_entry = '{rd: alu_rd_w_i, data: alu_data_w_i};
            end
            default: begin
                push = 1'b0;
            end
        endcase
    end

    assign mem_ready_w_o = mem_ready;
    assign alu_ready_w_o = alu_ready;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk_w_i),
        .rst   (res_w_i_h),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // A saturated counter can still take an issue if the same register drains now.
    assign iss_ready     = (cnt[iss_rd_w_i] != CNT_MAX) || (pop && (head.rd == iss_rd_w_i));
    assign iss_ready_w_o = iss_ready;
    assign iss_fire      = iss_valid_w_i && iss_ready && (iss_rd_w_i != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (iss_fire) begin
            inc_vec[iss_rd_w_i] = 1'b1;
        end
        if (pop) begin
            dec_vec[head.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
        if (res_w_i_h) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    underflow_chk : assert property (@(posedge clk_w_i) disable iff (res_w_i_h)
        (pop && !inc_vec[head.rd]) |-> (cnt[head.rd] != '0));

    always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
        if (res_w_i_h) begin
            wr_reg_w_o      <= '0;
            wr_data_w_o     <= '0;
            reg_wr_flag_w_o <= 1'b0;
        end else if (pop) begin
            wr_reg_w_o      <= head.rd;
            wr_data_w_o     <= head.data;
            reg_wr_flag_w_o <= 1'b1;
        end else begin
            reg_wr_flag_w_o <= 1'b0;
        end
    end

    assign chk_busy_1_w_o = (cnt[chk_reg_1_w_i] != '0);
    assign chk_busy_2_w_o = (cnt[chk_reg_2_w_i] != '0);

`ifdef WB_FORWARD_EN
    // Only the last outstanding write may be forwarded; an older in-flight
    // write to the same register would otherwise be mistaken for the final value.
    assign fwd_hit_1_w_o  = reg_wr_flag_w_o && (wr_reg_w_o == chk_reg_1_w_i) &&
                            (chk_reg_1_w_i != '0) && (cnt[chk_reg_1_w_i] == '0);
    assign fwd_hit_2_w_o  = reg_wr_flag_w_o && (wr_reg_w_o == chk_reg_2_w_i) &&
                            (chk_reg_2_w_i != '0) && (cnt[chk_reg_2_w_i] == '0);
    assign fwd_data_1_w_o = wr_data_w_o;
    assign fwd_data_2_w_o = wr_data_w_o;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: queue-based reference model checked every
// cycle, plus hand-computed expectations at each scenario's key points.
module tb_writeback_unit;

    localparam int DEPTH   = 4;
    localparam int CNT_MAX = 3;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        stall;
    logic [4:0]  chk_reg_1;
    logic [4:0]  chk_reg_2;
    logic        chk_busy_1;
    logic        chk_busy_2;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        wr_flag;
`ifdef WB_FORWARD_EN
    logic        fwd_hit_1;
    logic        fwd_hit_2;
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;
`endif

    int n_total = 0;
    int n_pass  = 0;

    writeback_unit dut (
        .clk_w_i         (clk),
        .res_w_i_h       (rst),
        .alu_valid_w_i   (alu_valid),
        .alu_rd_w_i      (alu_rd),
        .alu_data_w_i    (alu_data),
        .alu_ready_w_o   (alu_ready),
        .mem_valid_w_i   (mem_valid),
        .mem_rd_w_i      (mem_rd),
        .mem_data_w_i    (mem_data),
        .mem_ready_w_o   (mem_ready),
        .iss_valid_w_i   (iss_valid),
        .iss_rd_w_i      (iss_rd),
        .iss_ready_w_o   (iss_ready),
        .stall_w_i       (stall),
        .chk_reg_1_w_i   (chk_reg_1),
        .chk_reg_2_w_i   (chk_reg_2),
        .chk_busy_1_w_o  (chk_busy_1),
        .chk_busy_2_w_o  (chk_busy_2),
        .wr_reg_w_o      (wr_reg),
        .wr_data_w_o     (wr_data),
        .reg_wr_flag_w_o (wr_flag)
`ifdef WB_FORWARD_EN
        ,
        .fwd_hit_1_w_o   (fwd_hit_1),
        .fwd_hit_2_w_o   (fwd_hit_2),
        .fwd_data_1_w_o  (fwd_data_1),
        .fwd_data_2_w_o  (fwd_data_2)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [36:0] exp_q[$];
    int          m_cnt [32];
    logic        m_flag;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    function automatic bit model_full();
        return exp_q.size() >= DEPTH;
    endfunction

    function automatic bit model_mem_ready();
        return !model_full() || (mem_rd == 5'd0);
    endfunction

    function automatic bit model_alu_ready();
        return (!model_full() && !mem_valid) || (alu_rd == 5'd0);
    endfunction

    function automatic bit model_pops();
        return (exp_q.size() > 0) && !stall;
    endfunction

    function automatic bit model_iss_ready();
        bit drains;
        drains = model_pops() && (exp_q[0][36:32] == iss_rd);
        return (m_cnt[iss_rd] != CNT_MAX) || drains;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit          mem_go;
        bit          alu_go;
        bit          iss_go;
        bit          pop_now;
        logic [36:0] e;
        if (rst) begin
            exp_q.delete();
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_flag = 1'b0;
            m_reg  = '0;
            m_data = '0;
        end else begin
            mem_go  = mem_valid && model_mem_ready();
            alu_go  = alu_valid && model_alu_ready();
            iss_go  = iss_valid && model_iss_ready() && (iss_rd != 5'd0);
            pop_now = model_pops();
            if (pop_now) begin
                e      = exp_q.pop_front();
                m_flag = 1'b1;
                m_reg  = e[36:32];
                m_data = e[31:0];
            end else begin
                m_flag = 1'b0;
            end
            if (iss_go) m_cnt[iss_rd]++;
            if (pop_now && m_cnt[m_reg] > 0) m_cnt[m_reg]--;
            if (mem_go && mem_rd != 5'd0) exp_q.push_back({mem_rd, mem_data});
            else if (alu_go && alu_rd != 5'd0) exp_q.push_back({alu_rd, alu_data});
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("m_flag",   64'(wr_flag),    64'(m_flag));
            check("m_reg",    64'(wr_reg),     64'(m_reg));
            check("m_data",   64'(wr_data),    64'(m_data));
            check("m_alu_rdy", 64'(alu_ready), 64'(model_alu_ready()));
            check("m_mem_rdy", 64'(mem_ready), 64'(model_mem_ready()));
            check("m_iss_rdy", 64'(iss_ready), 64'(model_iss_ready()));
            check("m_busy1",  64'(chk_busy_1), 64'(m_cnt[chk_reg_1] != 0));
            check("m_busy2",  64'(chk_busy_2), 64'(m_cnt[chk_reg_2] != 0));
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        iss_valid = 0; iss_rd = 0; stall = 0;
        chk_reg_1 = 0; chk_reg_2 = 0;
        #1 rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        settle();
        check("init_flag", 64'(wr_flag), 64'd0);
        check("init_reg",  64'(wr_reg),  64'd0);
        check("init_alu_rdy", 64'(alu_ready), 64'd1);

        // Single ALU result
        step();
        iss_valid = 1; iss_rd = 5;
        step();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; chk_reg_1 = 5;
        settle();
        check("single_busy_before", 64'(chk_busy_1), 64'd1);
        step();
        alu_valid = 0;
        step();
        settle();
        check("single_flag", 64'(wr_flag), 64'd1);
        check("single_reg",  64'(wr_reg),  64'd5);
        check("single_data", 64'(wr_data), 64'hDEADBEEF);
        check("single_busy_after", 64'(chk_busy_1), 64'd0);
        step();
        check("single_flag_drop", 64'(wr_flag), 64'd0);

        // Simultaneous sources
        iss_valid = 1; iss_rd = 3;
        step();
        iss_rd = 4;
        step();
        iss_valid = 0;
        mem_valid = 1; mem_rd = 3; mem_data = 32'h11;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h22;
        settle();
        check("sim_alu_rdy", 64'(alu_ready), 64'd0);
        check("sim_mem_rdy", 64'(mem_ready), 64'd1);
        step();
        mem_valid = 0;
        settle();
        check("sim_alu_rdy2", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 0;
        settle();
        check("sim_w1_flag", 64'(wr_flag), 64'd1);
        check("sim_w1_reg",  64'(wr_reg),  64'd3);
        check("sim_w1_data", 64'(wr_data), 64'h11);
        step();
        check("sim_w2_flag", 64'(wr_flag), 64'd1);
        check("sim_w2_reg",  64'(wr_reg),  64'd4);
        check("sim_w2_data", 64'(wr_data), 64'h22);
        step();
        check("sim_idle", 64'(wr_flag), 64'd0);

        // Full FIFO under stall
        stall = 1; chk_reg_2 = 8;
        for (int i = 0; i < 4; i++) begin
            iss_valid = 1; iss_rd = 5'(8 + i);
            step();
        end
        iss_valid = 0;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 5'(8 + i); alu_data = 32'hA0 + 32'(i);
            step();
        end
        mem_valid = 1; mem_rd = 12; mem_data = 32'h12;
        alu_valid = 1; alu_rd = 13; alu_data = 32'h13;
        settle();
        check("full_mem_rdy", 64'(mem_ready), 64'd0);
        check("full_alu_rdy", 64'(alu_ready), 64'd0);
        mem_rd = 0;
        settle();
        check("full_mem_x0_rdy", 64'(mem_ready), 64'd1);
        check("full_alu_blocked", 64'(alu_ready), 64'd0);
        step();
        mem_valid = 0; alu_rd = 0; alu_data = 32'hFFFFFFFF;
        settle();
        check("full_alu_x0_rdy", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 0; stall = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_flag", 64'(wr_flag), 64'd1);
            check("drain_reg",  64'(wr_reg),  64'(8 + i));
            check("drain_data", 64'(wr_data), 64'(32'hA0 + 32'(i)));
        end
        step();
        check("drain_idle", 64'(wr_flag), 64'd0);

        // Scoreboard saturation
        iss_valid = 1; iss_rd = 7;
        repeat (3) step();
        settle();
        check("sat_iss_rdy", 64'(iss_ready), 64'd0);
        iss_valid = 0; stall = 1;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        step();
        alu_valid = 0; iss_valid = 1; iss_rd = 7;
        settle();
        check("sat_stalled_rdy", 64'(iss_ready), 64'd0);
        stall = 0;
        settle();
        check("sat_pop_rdy", 64'(iss_ready), 64'd1);
        step();
        iss_valid = 0; chk_reg_1 = 7;
        settle();
        check("sat_pop_flag", 64'(wr_flag), 64'd1);
        check("sat_pop_reg",  64'(wr_reg),  64'd7);
        check("sat_still_busy", 64'(chk_busy_1), 64'd1);
        check("sat_still_max",  64'(iss_ready),  64'd0);

        // x0 write
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF; chk_reg_2 = 0;
        settle();
        check("x0_alu_rdy", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 0;
        repeat (3) begin
            step();
            check("x0_no_flag", 64'(wr_flag), 64'd0);
        end
        check("x0_busy", 64'(chk_busy_2), 64'd0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1; iss_rd = 5'(20 + i);
            step();
        end
        iss_valid = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 32'h200 + 32'(i);
            step();
        end
        alu_valid = 0;
        #2 rst = 1'b1;
        settle();
        check("rst_flag", 64'(wr_flag), 64'd0);
        check("rst_reg",  64'(wr_reg),  64'd0);
        check("rst_data", 64'(wr_data), 64'd0);
        for (int r = 0; r < 32; r++) begin
            chk_reg_1 = 5'(r);
            settle();
            check("rst_busy", 64'(chk_busy_1), 64'd0);
        end
        step();
        rst = 1'b0;
        stall = 0;
        settle();
        check("rst_alu_rdy", 64'(alu_ready), 64'd1);
        repeat (3) step();
        check("rst_no_write", 64'(wr_flag), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
